// File: rtl/hdr_dispatcher_if.sv
// rtl/hdr_dispatcher_if.sv - signal bundle between I3C engine, HDR sub-engines and hdr_dispatcher
interface hdr_dispatcher_if #(
  parameter int SEL_N  = 11,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
);
  logic                 i_hdr_en;
  logic                 i_CP;
  logic                 i_TOC;
  logic [2:0]           i_MODE;
  logic                 i_ccc_done;
  logic                 i_ddr_done;
  logic                 i_bt_done;
  logic                 o_ccc_en;
  logic                 o_ddr_en;
  logic                 o_bt_en;
  logic [2*SEL_N-1:0]   o_path_sel;
  logic [ADDR_W-1:0]    o_regf_addr_special;
  logic                 o_done;
  logic                 o_abort;
  logic [CNT_W-1:0]     o_xfer_cnt;

  modport slave (
    input  i_hdr_en, i_CP, i_TOC, i_MODE, i_ccc_done, i_ddr_done, i_bt_done,
    output o_ccc_en, o_ddr_en, o_bt_en, o_path_sel, o_regf_addr_special,
           o_done, o_abort, o_xfer_cnt
  );

  modport master (
    output i_hdr_en, i_CP, i_TOC, i_MODE, i_ccc_done, i_ddr_done, i_bt_done,
    input  o_ccc_en, o_ddr_en, o_bt_en, o_path_sel, o_regf_addr_special,
           o_done, o_abort, o_xfer_cnt
  );
endinterface

// File: rtl/hdr_dispatcher.sv
// rtl/hdr_dispatcher.sv - HDR session sequencer over CCC, DDR and BT sub-engines
module hdr_dispatcher #(
  parameter int SEL_N      = 11,
  parameter int ADDR_W     = 12,
  parameter int IDLE_ADDR  = 1000,
  parameter int DUMMY_ADDR = 450,
  parameter int DDR_CODE   = 6,
  parameter int BT_CODE    = 7,
  parameter int TMO_W      = 16,
  parameter int TMO_CYC    = 50000,
  parameter int CNT_W      = 8
) (
  input  logic            i_sys_clk,
  input  logic            i_sys_rst,
  hdr_dispatcher_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CCC, S_DUMMY, S_DDR, S_BT, S_GAP, S_EXIT} state_t;
  typedef enum logic [1:0] {T_NONE, T_CCC, T_DDR, T_BT} tgt_t;

  localparam logic [1:0] SEL_DDR = 2'b00;
  localparam logic [1:0] SEL_CCC = 2'b01;
  localparam logic [1:0] SEL_BT  = 2'b10;

  state_t            state, state_nx;
  tgt_t              tgt_q, tgt_nx, tgt_in;
  logic [1:0]        code_q, code_nx;
  logic [TMO_W-1:0]  wdog_q, wdog_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              abort_nx, own_done, wdog_exp;
  logic              ccc_en_q, ddr_en_q, bt_en_q, done_q, abort_q;
  logic [ADDR_W-1:0] addr_q;

  function automatic state_t state_of(input tgt_t t);
    case (t)
      T_CCC:   return S_CCC;
      T_DDR:   return S_DDR;
      T_BT:    return S_BT;
      default: return S_EXIT;
    endcase
  endfunction

  function automatic logic [1:0] code_of(input tgt_t t);
    case (t)
      T_CCC:   return SEL_CCC;
      T_BT:    return SEL_BT;
      default: return SEL_DDR;
    endcase
  endfunction

  always_comb begin
    tgt_in = T_NONE;
    if (bus.i_CP)                        tgt_in = T_CCC;
    else if (bus.i_MODE == 3'(DDR_CODE)) tgt_in = T_DDR;
    else if (bus.i_MODE == 3'(BT_CODE))  tgt_in = T_BT;
  end

  // Only the engine owning the current state may end it; the dummy CCC is run by the CCC engine.
  always_comb begin
    own_done = 1'b0;
    case (state)
      S_CCC, S_DUMMY: own_done = bus.i_ccc_done;
      S_DDR:          own_done = bus.i_ddr_done;
      S_BT:           own_done = bus.i_bt_done;
      default:        own_done = 1'b0;
    endcase
  end

  assign wdog_exp = (wdog_q == TMO_W'(TMO_CYC - 1));

  always_comb begin
    state_nx = state;
    tgt_nx   = tgt_q;
    code_nx  = code_q;
    cnt_nx   = cnt_q;
    wdog_nx  = '0;
    abort_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_hdr_en) begin
          state_nx = state_of(tgt_in);
          if (tgt_in != T_NONE) begin
            code_nx = code_of(tgt_in);
            cnt_nx  = '0;
          end
        end
      end
      S_CCC, S_DDR, S_BT, S_DUMMY: begin
        if (!bus.i_hdr_en) begin
          state_nx = S_IDLE;
        end else if (own_done && state == S_DUMMY) begin
          state_nx = S_GAP;
          code_nx  = code_of(tgt_q);
        end else if (own_done) begin
          cnt_nx = cnt_q + 1'b1;
          if (bus.i_TOC || tgt_in == T_NONE) begin
            state_nx = S_EXIT;
          end else begin
            tgt_nx = tgt_in;
            if (state == S_CCC && tgt_in != T_CCC) begin
              state_nx = S_DUMMY;
            end else begin
              state_nx = S_GAP;
              code_nx  = code_of(tgt_in);
            end
          end
        end else if (wdog_exp) begin
          state_nx = S_EXIT;
          abort_nx = 1'b1;
        end else begin
          wdog_nx = wdog_q + 1'b1;
        end
      end
      S_GAP:   state_nx = bus.i_hdr_en ? state_of(tgt_q) : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state    <= S_IDLE;
      tgt_q    <= T_NONE;
      code_q   <= SEL_DDR;
      wdog_q   <= '0;
      cnt_q    <= '0;
      ccc_en_q <= 1'b0;
      ddr_en_q <= 1'b0;
      bt_en_q  <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      addr_q   <= ADDR_W'(IDLE_ADDR);
    end else begin
      state    <= state_nx;
      tgt_q    <= tgt_nx;
      code_q   <= code_nx;
      wdog_q   <= wdog_nx;
      cnt_q    <= cnt_nx;
      ccc_en_q <= (state_nx == S_CCC) || (state_nx == S_DUMMY);
      ddr_en_q <= (state_nx == S_DDR);
      bt_en_q  <= (state_nx == S_BT);
      done_q   <= (state_nx == S_EXIT);
      abort_q  <= abort_nx;
      addr_q   <= (state_nx == S_DUMMY) ? ADDR_W'(DUMMY_ADDR) : ADDR_W'(IDLE_ADDR);
    end
  end

  assign bus.o_ccc_en            = ccc_en_q;
  assign bus.o_ddr_en            = ddr_en_q;
  assign bus.o_bt_en             = bt_en_q;
  assign bus.o_path_sel          = {SEL_N{code_q}};
  assign bus.o_regf_addr_special = addr_q;
  assign bus.o_done              = done_q;
  assign bus.o_abort             = abort_q;
  assign bus.o_xfer_cnt          = cnt_q;
endmodule

// File: tb/tb_hdr_dispatcher.sv
// tb/tb_hdr_dispatcher.sv - scoreboard bench: expected output changes queued by stimulus, popped by monitor
module tb_hdr_dispatcher;
  localparam int SEL_N = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdr_dispatcher_if #(.SEL_N(SEL_N), .ADDR_W(12), .CNT_W(8)) bus ();

  hdr_dispatcher #(
    .SEL_N(SEL_N), .ADDR_W(12), .IDLE_ADDR(1000), .DUMMY_ADDR(450), .DDR_CODE(6),
    .BT_CODE(7), .TMO_W(16), .TMO_CYC(16), .CNT_W(8)
  ) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus)
  );

  typedef struct packed {
    logic               ccc;
    logic               ddr;
    logic               bt;
    logic [2*SEL_N-1:0] sel;
    logic [11:0]        addr;
    logic               dn;
    logic               ab;
    logic [7:0]         cnt;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dur;
  } exp_t;

  exp_t  q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    mon_go = 0;
  snap_t prev, cur;
  exp_t  e;
  int    run = 0;
  int    step = 0;
  bit    first = 1;

  // dur = cycles the previous output pattern must have lasted (0 = not checked)
  task automatic exp_push(input logic c, input logic d, input logic b, input logic [1:0] code,
                          input logic dummy, input logic dn, input logic ab,
                          input logic [7:0] cnt, input int dur);
    exp_t x;
    x.s.ccc  = c;
    x.s.ddr  = d;
    x.s.bt   = b;
    x.s.sel  = {SEL_N{code}};
    x.s.addr = dummy ? 12'd450 : 12'd1000;
    x.s.dn   = dn;
    x.s.ab   = ab;
    x.s.cnt  = cnt;
    x.dur    = dur;
    q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic cp, input logic [2:0] mode, input logic toc);
    bus.i_hdr_en = 1'b1;
    bus.i_CP     = cp;
    bus.i_MODE   = mode;
    bus.i_TOC    = toc;
  endtask

  // which: 0 = CCC, 1 = DDR, 2 = BT; the done is sampled on the n-th edge from now
  task automatic engine(input int which, input int n, input logic cp, input logic [2:0] mode,
                        input logic toc);
    tick(n);
    bus.i_CP   = cp;
    bus.i_MODE = mode;
    bus.i_TOC  = toc;
    case (which)
      0:       bus.i_ccc_done = 1'b1;
      1:       bus.i_ddr_done = 1'b1;
      default: bus.i_bt_done  = 1'b1;
    endcase
    tick(1);
    bus.i_ccc_done = 1'b0;
    bus.i_ddr_done = 1'b0;
    bus.i_bt_done  = 1'b0;
  endtask

  initial begin
    wait (mon_go);
    forever begin
      @(negedge clk);
      cur = {bus.o_ccc_en, bus.o_ddr_en, bus.o_bt_en, bus.o_path_sel,
             bus.o_regf_addr_special, bus.o_done, bus.o_abort, bus.o_xfer_cnt};
      if (first || cur !== prev) begin
        n_cmp++;
        step++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change step %0d: got %h, want no change", step, cur);
        end else begin
          e = q.pop_front();
          if (cur !== e.s || (e.dur != 0 && run != e.dur)) begin
            n_fail++;
            $display("FAIL out_step %0d: got %h after %0d cycles, want %h after %0d cycles",
                     step, cur, run, e.s, e.dur);
          end
        end
        prev  = cur;
        run   = 1;
        first = 0;
      end else begin
        run++;
      end
    end
  end

  initial begin
    bus.i_hdr_en   = 1'b0;
    bus.i_CP       = 1'b0;
    bus.i_TOC      = 1'b0;
    bus.i_MODE     = 3'd0;
    bus.i_ccc_done = 1'b0;
    bus.i_ddr_done = 1'b0;
    bus.i_bt_done  = 1'b0;

    exp_push(0, 0, 0, 2'b00, 0, 0, 0, 8'd0, 0);
    tick(3);
    rst    = 1'b0;
    mon_go = 1'b1;
    tick(3);

    // single DDR, TOC=1, 10 active cycles; stray CCC/BT dones ignored
    exp_push(0, 1, 0, 2'b00, 0, 0, 0, 8'd0, 0);
    exp_push(0, 0, 0, 2'b00, 0, 1, 0, 8'd1, 10);
    exp_push(0, 0, 0, 2'b00, 0, 0, 0, 8'd1, 1);
    start(1'b0, 3'd6, 1'b1);
    tick(4);
    bus.i_ccc_done = 1'b1;
    bus.i_bt_done  = 1'b1;
    tick(1);
    bus.i_ccc_done = 1'b0;
    bus.i_bt_done  = 1'b0;
    engine(1, 5, 1'b0, 3'd6, 1'b1);
    bus.i_hdr_en = 1'b0;
    tick(3);

    // CCC then DDR through the dummy CCC and a gap
    exp_push(1, 0, 0, 2'b01, 0, 0, 0, 8'd0, 0);
    exp_push(1, 0, 0, 2'b01, 1, 0, 0, 8'd1, 4);
    exp_push(0, 0, 0, 2'b00, 0, 0, 0, 8'd1, 3);
    exp_push(0, 1, 0, 2'b00, 0, 0, 0, 8'd1, 1);
    exp_push(0, 0, 0, 2'b00, 0, 1, 0, 8'd2, 2);
    exp_push(0, 0, 0, 2'b00, 0, 0, 0, 8'd2, 1);
    start(1'b1, 3'd0, 1'b0);
    engine(0, 4, 1'b0, 3'd6, 1'b0);
    engine(0, 2, 1'b0, 3'd6, 1'b0);
    engine(1, 2, 1'b0, 3'd6, 1'b1);
    bus.i_hdr_en = 1'b0;
    tick(3);

    // three back-to-back DDR transfers, TOC 0,0,1
    exp_push(0, 1, 0, 2'b00, 0, 0, 0, 8'd0, 0);
    exp_push(0, 0, 0, 2'b00, 0, 0, 0, 8'd1, 3);
    exp_push(0, 1, 0, 2'b00, 0, 0, 0, 8'd1, 1);
    exp_push(0, 0, 0, 2'b00, 0, 0, 0, 8'd2, 2);
    exp_push(0, 1, 0, 2'b00, 0, 0, 0, 8'd2, 1);
    exp_push(0, 0, 0, 2'b00, 0, 1, 0, 8'd3, 2);
    exp_push(0, 0, 0, 2'b00, 0, 0, 0, 8'd3, 1);
    start(1'b0, 3'd6, 1'b0);
    engine(1, 3, 1'b0, 3'd6, 1'b0);
    engine(1, 2, 1'b0, 3'd6, 1'b0);
    engine(1, 2, 1'b0, 3'd6, 1'b1);
    bus.i_hdr_en = 1'b0;
    tick(3);

    // BT watchdog expiry after 16 cycles
    exp_push(0, 0, 1, 2'b10, 0, 0, 0, 8'd0, 0);
    exp_push(0, 0, 0, 2'b10, 0, 1, 1, 8'd0, 16);
    exp_push(0, 0, 0, 2'b10, 0, 0, 0, 8'd0, 1);
    start(1'b0, 3'd7, 1'b1);
    tick(17);
    bus.i_hdr_en = 1'b0;
    tick(3);

    // BT done on the expiry cycle wins over the watchdog
    exp_push(0, 0, 1, 2'b10, 0, 0, 0, 8'd0, 0);
    exp_push(0, 0, 0, 2'b10, 0, 1, 0, 8'd1, 16);
    exp_push(0, 0, 0, 2'b10, 0, 0, 0, 8'd1, 1);
    start(1'b0, 3'd7, 1'b1);
    engine(2, 16, 1'b0, 3'd7, 1'b1);
    bus.i_hdr_en = 1'b0;
    tick(3);

    // CCC restart through a gap, then i_hdr_en drops mid-CCC
    exp_push(1, 0, 0, 2'b01, 0, 0, 0, 8'd0, 0);
    exp_push(0, 0, 0, 2'b01, 0, 0, 0, 8'd1, 3);
    exp_push(1, 0, 0, 2'b01, 0, 0, 0, 8'd1, 1);
    exp_push(0, 0, 0, 2'b01, 0, 0, 0, 8'd1, 3);
    start(1'b1, 3'd0, 1'b0);
    engine(0, 3, 1'b1, 3'd0, 1'b0);
    tick(3);
    bus.i_hdr_en = 1'b0;
    tick(3);

    // unsupported mode: immediate done, no enable
    exp_push(0, 0, 0, 2'b01, 0, 1, 0, 8'd1, 0);
    exp_push(0, 0, 0, 2'b01, 0, 0, 0, 8'd1, 1);
    start(1'b0, 3'd3, 1'b1);
    tick(1);
    bus.i_hdr_en = 1'b0;
    tick(3);

    // reset mid-DDR with i_hdr_en still high
    exp_push(0, 1, 0, 2'b00, 0, 0, 0, 8'd0, 0);
    exp_push(0, 0, 0, 2'b00, 0, 0, 0, 8'd1, 2);
    exp_push(0, 1, 0, 2'b00, 0, 0, 0, 8'd1, 1);
    exp_push(0, 0, 0, 2'b00, 0, 0, 0, 8'd0, 2);
    start(1'b0, 3'd6, 1'b0);
    engine(1, 2, 1'b0, 3'd6, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst          = 1'b0;
    bus.i_hdr_en = 1'b0;
    tick(5);

    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected output changes never seen, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hdr_dispatcher.md
Name: hdr_dispatcher

Overview:
- Parametrised successor of the HDR engine controller. Sequences HDR sessions across three sub-engines: CCC, DDR and BT (bulk transport).
- Drives a per-path mux select vector and the register-file special address.
- Adds a dummy-CCC insertion state, a one-cycle enable gap between back-to-back transactions, a per-transaction watchdog and a transaction counter.
- Sits between the I3C engine and the HDR sub-engines.

Parameters:
SEL_N, 11, number of datapath mux selectors driven (tx_en, rx_en, tx_mode, ... sdahand_pp_od)
ADDR_W, 12, width of o_regf_addr_special
IDLE_ADDR, 1000, special address driven when no dummy is in progress
DUMMY_ADDR, 450, special address holding the dummy-CCC value
DDR_CODE, 6, i_MODE value selecting DDR
BT_CODE, 7, i_MODE value selecting BT
TMO_W, 16, watchdog counter width
TMO_CYC, 50000, cycles without an engine done before abort
CNT_W, 8, width of the transaction counter

Ports:
i_sys_clk  in  1  system clock
i_sys_rst  in  1  synchronous, active-high reset
i_hdr_en  in  1  session enable from I3C engine (level)
i_CP  in  1  command present: 1 = CCC, 0 = normal transfer
i_TOC  in  1  term of completion: 1 = exit after current transfer, 0 = restart
i_MODE  in  3  HDR mode code
i_ccc_done  in  1  CCC engine done pulse
i_ddr_done  in  1  DDR engine done pulse
i_bt_done  in  1  BT engine done pulse
o_ccc_en  out  1  CCC engine enable (level)
o_ddr_en  out  1  DDR engine enable (level)
o_bt_en  out  1  BT engine enable (level)
o_path_sel  out  2*SEL_N  selector i is bits [2i+1:2i]; 00 = DDR, 01 = CCC, 10 = BT; all selectors carry the same code
o_regf_addr_special  out  ADDR_W  register-file special address
o_done  out  1  one-cycle session-complete pulse
o_abort  out  1  one-cycle watchdog-abort pulse, coincident with o_done
o_xfer_cnt  out  CNT_W  completed transactions in the current session

Behaviour:
- Reset (synchronous, i_sys_rst=1 at a clock edge, also mid-transfer):
  - State IDLE.
  - All enables 0, o_path_sel 0, o_regf_addr_special = IDLE_ADDR.
  - o_done, o_abort and o_xfer_cnt 0; watchdog 0.
- States: IDLE, CCC, DUMMY, DDR, BT, GAP, EXIT. All outputs are registered.
- Target selection, target(CP, MODE):
  - CP=1 -> CCC.
  - CP=0 and MODE=DDR_CODE -> DDR.
  - CP=0 and MODE=BT_CODE -> BT.
  - Otherwise -> none.
- IDLE:
  - i_hdr_en=1 and target is valid: enter the target state. Enable and o_path_sel take effect the cycle after i_hdr_en is sampled (1-cycle latency). o_xfer_cnt clears to 0.
  - Target is none: go to EXIT.
- Active states (CCC/DDR/BT):
  - Own enable held 1; o_path_sel holds the state's code.
  - Watchdog increments each cycle and clears on state entry.
- Own engine done sampled:
  - o_xfer_cnt increments; wraps at 2^CNT_W-1 -> 0.
  - TOC=1 or target=none: go to EXIT.
  - TOC=0, current state CCC, target is DDR or BT: go to DUMMY.
  - TOC=0, any other valid target: go to GAP, with the target latched.
- DUMMY:
  - o_ccc_en=1, CCC select, o_regf_addr_special = DUMMY_ADDR.
  - On i_ccc_done: go to GAP with the latched target. Address returns to IDLE_ADDR. No o_xfer_cnt increment.
- GAP: exactly one cycle with all enables 0; o_path_sel already switched to the target's code. Next state is the target. Guarantees a rising enable edge even for same-engine restarts.
- EXIT: o_done=1 for one cycle, all enables 0, then IDLE.
- Watchdog: counter reaching TMO_CYC-1 in CCC/DDR/BT/DUMMY without a done -> EXIT with o_abort=1.
- Done sampled only from the engine owning the current state; other done inputs are ignored.
- Priority: reset > i_hdr_en=0 > done > watchdog.
  - i_hdr_en=0 in any non-IDLE state: go to IDLE next cycle, enables 0, no o_done.
  - Done and watchdog expiry in the same cycle: done wins.
- o_xfer_cnt holds its value in IDLE until the next session starts.

Test Plan:
- Reset with i_hdr_en=1 mid-DDR -> next cycle all enables 0, o_regf_addr_special=1000, o_xfer_cnt=0.
- CP=0, MODE=6, TOC=1; i_ddr_done after 10 cycles -> o_ddr_en high 10 cycles, o_path_sel all 00, o_done pulse 1 cycle later, o_xfer_cnt=1.
- CCC with TOC=0, then CP=0, MODE=6 -> after i_ccc_done: DUMMY (addr 450, o_ccc_en=1); after second i_ccc_done: 1 gap cycle, then o_ddr_en=1, o_xfer_cnt=1.
- Three back-to-back DDR transfers with TOC=0,0,1 -> o_ddr_en low exactly 1 cycle between each, o_done after the third, o_xfer_cnt=3.
- BT with no i_bt_done, TMO_CYC=16 -> o_bt_en high 16 cycles, then o_done and o_abort pulse together; done arriving on the expiry cycle -> no abort.
- i_hdr_en drops during CCC -> enables 0 next cycle, IDLE, no o_done; MODE=3 with CP=0 in IDLE -> immediate o_done, no enable asserted.
